// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the Execute-stage multiply/divide engine.
// Operand magnitudes and op classification live here so both the unit and its divider agree.
package muldiv_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] i64;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_NONE  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic is_mul_op(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_muldiv(input op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  // Two's-complement negation leaves 0x8000_0000 unchanged, which is the wanted unsigned magnitude.
  function automatic word_t magnitude(input word_t x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_divu.sv
// Radix-2 restoring divider: one quotient bit per clock, 32 steps after start.
// 'last' is high during the final step so the caller can capture 'result' on that edge.
module divu_iter
  import muldiv_unit_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  start,
  input  logic  flush,
  input  word_t dividend,
  input  word_t divisor,
  output logic  last,
  output i64    result
);

  logic        busy;
  logic [5:0]  cnt;
  word_t       dvd;
  word_t       dsr;
  word_t       rem;
  logic [32:0] rem_sh;
  logic        ge;
  word_t       rem_nx;
  word_t       dvd_nx;

  // The remainder is always below the divisor after a step, so 32 stored bits suffice;
  // the shifted value needs 33 bits so divisors >= 0x8000_0000 compare correctly.
  // NOTE: always_comb assigns every output first so no path can infer a latch.
  always_comb begin
    rem_sh = {rem, dvd[31]};
    ge     = rem_sh >= {1'b0, dsr};
    rem_nx = rem_sh[31:0];
    if (ge) rem_nx = 32'(rem_sh - {1'b0, dsr});
    dvd_nx = {dvd[30:0], ge};
  end

  assign last   = busy && (cnt == 6'(DIV_ITERS - 1));
  assign result = {rem_nx, dvd_nx};

  // NOTE: datapath registers are reset too, so no stale operand is visible after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      cnt  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      rem  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      dvd  <= dividend;
      dsr  <= divisor;
      rem  <= '0;
    end else if (busy) begin
      rem <= rem_nx;
      dvd <= dvd_nx;
      cnt <= cnt + 6'd1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine producing unsigned magnitude results for HI/LO writeback.
// Sign fix-up and MADD/MSUB accumulation are done downstream.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  flush,
  input  logic  in_valid,
  output logic  in_ready,
  input  op_t   op,
  input  word_t a,
  input  word_t b,
  output logic  out_valid,
  output i64    mult_c,
  output i64    div_c
);

  muldiv_state_t state;
  word_t         a_mag;
  word_t         b_mag;
  word_t         pp_ll;
  word_t         pp_lh;
  word_t         pp_hl;
  word_t         pp_hh;
  logic [32:0]   mid_sum;
  i64            product;
  logic          accept;
  logic          op_is_mul;
  logic          op_is_div;
  logic          div_last;
  i64            div_result;

  assign a_mag     = magnitude(a, is_signed_muldiv(op));
  assign b_mag     = magnitude(b, is_signed_muldiv(op));
  assign op_is_mul = is_mul_op(op);
  assign op_is_div = is_div_op(op);
  assign in_ready  = (state == S_IDLE) || (state == S_DONE);
  assign accept    = in_valid && in_ready && (op_is_mul || op_is_div) && !flush;

  // Cross terms share weight 2^16; their 33-bit sum keeps the carry.
  assign mid_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
  assign product = {pp_hh, 32'h0} + {15'h0, mid_sum, 16'h0} + {32'h0, pp_ll};

  divu_iter u_divu (
    .clk      (clk),
    .resetn   (resetn),
    .start    (accept && op_is_div),
    .flush    (flush),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (div_last),
    .result   (div_result)
  );

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      mult_c    <= '0;
      div_c     <= '0;
      pp_ll     <= '0;
      pp_lh     <= '0;
      pp_hl     <= '0;
      pp_hh     <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b0;
      if (op_is_mul) begin
        state <= S_MUL;
        pp_ll <= 32'(a_mag[15:0])  * 32'(b_mag[15:0]);
        pp_lh <= 32'(a_mag[15:0])  * 32'(b_mag[31:16]);
        pp_hl <= 32'(a_mag[31:16]) * 32'(b_mag[15:0]);
        pp_hh <= 32'(a_mag[31:16]) * 32'(b_mag[31:16]);
      end else begin
        state <= S_DIV;
      end
    end else begin
      case (state)
        S_MUL: begin
          mult_c    <= product;
          state     <= S_DONE;
          out_valid <= 1'b1;
        end
        S_DIV: begin
          if (div_last) begin
            div_c     <= div_result;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
